rs_alu_station: RTL
===================

Name: rs_alu_station

Overview:
- Parametrised reservation station for the out-of-order RV32I core. Sits between the decoder/rename stage and one ALU.
- Holds up to RS_SIZE in-flight ALU/branch/jump ops and captures source operands from NUM_CDB common-data-bus channels.
- Issues one ready op per cycle to the ALU over a valid/ready handshake. Supports a full flush on branch mispredict.

Parameters:
- ROB_WIDTH, 4, bits of ROB tag.
- RS_SIZE, 8, number of station entries; must be ≥2.
- NUM_CDB, 2, number of CDB broadcast channels.
- OP_WIDTH, 6, width of the internal op code.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- clear  in  1  synchronous flush (mispredict)
- disp_valid  in  1  dispatch request
- disp_op  in  OP_WIDTH  op code
- disp_vj, disp_vk  in  32 each  operand values, valid when the matching q*_valid is 0
- disp_qj_valid, disp_qk_valid  in  1 each  operand pending
- disp_qj, disp_qk  in  ROB_WIDTH each  producer ROB tags
- disp_imm, disp_pc  in  32 each  immediate, instruction PC
- disp_tag  in  ROB_WIDTH  destination ROB tag
- full  out  1  no free entry
- count  out  $clog2(RS_SIZE)+1  occupied entries
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*ROB_WIDTH  flattened tags, channel 0 in LSBs
- cdb_data  in  NUM_CDB*32  flattened results
- issue_valid  out  1  issue register holds an op
- issue_ready  in  1  ALU accepts
- issue_op, issue_a, issue_b, issue_imm, issue_pc, issue_tag  out  OP_WIDTH/32/32/32/32/ROB_WIDTH  issued op; issue_a = vj, issue_b = vk

Behaviour:
- Reset:
  - All entries not busy; count=0, full=0.
  - issue_valid=0; all issue_* data outputs 0.
- rdy_in=0: no state changes. Dispatch and CDB inputs are ignored; upstream stalls under the same rdy_in.
- clear=1 (with rdy_in=1), at the next edge:
  - All entries freed; issue_valid←0; count←0.
  - A same-cycle dispatch is dropped. clear takes priority over everything.
- Dispatch:
  - Accepted at an edge when disp_valid && !full.
  - Written into the lowest-index free entry. full and count are registered and reflect state after the edge.
- Dispatch-time bypass: if a pending operand's q tag matches any valid CDB channel in the accept cycle, the entry stores the CDB data as ready.
- Wakeup: each edge, every busy entry with a pending operand whose tag equals a valid cdb_tag[c] captures cdb_data[c] and clears pending.
  - Duplicate tags on two channels: the lowest channel wins.
  - Both operands may wake in the same cycle.
- Ready: entry busy with neither operand pending.
- Selection:
  - Oldest ready entry wins. Age is tracked by a per-entry age matrix updated on allocate and free.
  - Selection uses register state only. An op woken at edge E is issuable from the cycle after E, not at E.
- Issue register:
  - Load enable = !issue_valid || issue_ready.
  - If load enable is set and a ready entry exists: copy the entry into issue_*, set issue_valid=1, free the entry at the same edge.
  - If load enable is set and no entry is ready: issue_valid←0.
  - While issue_valid && !issue_ready, all issue_* outputs stay stable.
- Latency: a dispatch with both operands ready, accepted at edge E0, with an idle ALU gives issue_valid=1 after E0+1.
- Same-edge events:
  - An entry freed by issue and a new dispatch in the same cycle: the freed slot is reusable from the next cycle only.
  - count updates as count + accept − issue.
- full=1: disp_valid is ignored with no side effects. The decoder must hold the op.
- Entries are never overwritten while busy. Reset mid-operation clears everything asynchronously.

Decomposition:
- Shared package rs_pkg: op-code constants (ADD…LUI, 6-bit encodings used by the decoder and ALU) and a packed rs_entry_t struct (busy, op, vj, vk, qj/qk + pending bits, imm, pc, tag).
- Sub-module rs_age_select: age matrix plus oldest-ready picker. Inputs: alloc one-hot, free one-hot, ready vector. Outputs: grant one-hot and valid.

Test Plan:
- Ready dispatch: dispatch ADD, vj=5, vk=7, tag=3, both operands ready, issue_ready=1 → after E0+1 issue_valid=1, issue_a=5, issue_b=7, issue_tag=3; count returns to 0.
- Wakeup: dispatch with qj=2 pending. Drive cdb_valid[1]=1, cdb_tag=2, cdb_data=0xDEADBEEF at a later edge → issue_a=0xDEADBEEF the next cycle, not before.
- Bypass: dispatch with qk=5 while CDB channel 0 broadcasts tag 5 / 0x10 in the same cycle → entry is ready; issues with issue_b=0x10.
- Backpressure and age: fill 8 entries, full=1. Hold issue_ready=0 for 3 cycles → issue_* stable. Then ordering follows dispatch order even after a mid-queue wakeup.
- Flush: 4 entries busy plus issue_valid=1; assert clear together with disp_valid → next cycle count=0, issue_valid=0, dispatched op absent.
- Freeze and reset: rdy_in=0 during a CDB broadcast → no wakeup. rst_in pulse mid-issue → all outputs 0 immediately.

Source files
------------

// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg: types shared by the ALU reservation station, the decoder and the ALU.
//   - RS_TAG_W / RS_OP_W : ROB tag width and internal op-code width of the core
//   - alu_op_e           : 6-bit internal op-code encodings (ADD ... LUI)
//   - rs_entry_t         : one reservation-station slot
// ---------------------------------------------------------------------------
package rs_pkg;

    localparam int RS_TAG_W = 4;
    localparam int RS_OP_W  = 6;

    typedef enum logic [RS_OP_W-1:0] {
        OP_ADD   = 6'd0,
        OP_SUB   = 6'd1,
        OP_SLL   = 6'd2,
        OP_SLT   = 6'd3,
        OP_SLTU  = 6'd4,
        OP_XOR   = 6'd5,
        OP_SRL   = 6'd6,
        OP_SRA   = 6'd7,
        OP_OR    = 6'd8,
        OP_AND   = 6'd9,
        OP_ADDI  = 6'd10,
        OP_SLTI  = 6'd11,
        OP_SLTIU = 6'd12,
        OP_XORI  = 6'd13,
        OP_ORI   = 6'd14,
        OP_ANDI  = 6'd15,
        OP_SLLI  = 6'd16,
        OP_SRLI  = 6'd17,
        OP_SRAI  = 6'd18,
        OP_BEQ   = 6'd19,
        OP_BNE   = 6'd20,
        OP_BLT   = 6'd21,
        OP_BGE   = 6'd22,
        OP_BLTU  = 6'd23,
        OP_BGEU  = 6'd24,
        OP_JAL   = 6'd25,
        OP_JALR  = 6'd26,
        OP_AUIPC = 6'd27,
        OP_LUI   = 6'd28
    } alu_op_e;

    // One station slot. vj/vk are only meaningful once the matching *_pend
    // bit is clear; while pending, qj/qk name the producing ROB entry.
    typedef struct packed {
        logic                busy;
        logic [RS_OP_W-1:0]  op;
        logic [31:0]         vj;
        logic [31:0]         vk;
        logic                qj_pend;
        logic [RS_TAG_W-1:0] qj;
        logic                qk_pend;
        logic [RS_TAG_W-1:0] qk;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic [RS_TAG_W-1:0] tag;
    } rs_entry_t;

endpackage

// File: rtl/rs_alu_station_if.sv
// ---------------------------------------------------------------------------
// rs_alu_station_if: dispatch, CDB and issue buses of the ALU station.
//   dispatch : disp_valid, disp_op, disp_vj/vk, disp_qj/qk(_valid),
//              disp_imm, disp_pc, disp_tag  -> full, count
//   CDB      : cdb_valid[NUM_CDB], flattened cdb_tag / cdb_data (ch 0 in LSBs)
//   issue    : issue_valid/issue_ready handshake plus issue_op/a/b/imm/pc/tag
// Modports: slave = the station, master = the surrounding pipeline.
// ---------------------------------------------------------------------------
interface rs_alu_station_if #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_SIZE   = 8,
    parameter int NUM_CDB   = 2,
    parameter int OP_WIDTH  = 6
);
    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    logic                          disp_valid;
    logic [OP_WIDTH-1:0]           disp_op;
    logic [31:0]                   disp_vj;
    logic [31:0]                   disp_vk;
    logic                          disp_qj_valid;
    logic                          disp_qk_valid;
    logic [ROB_WIDTH-1:0]          disp_qj;
    logic [ROB_WIDTH-1:0]          disp_qk;
    logic [31:0]                   disp_imm;
    logic [31:0]                   disp_pc;
    logic [ROB_WIDTH-1:0]          disp_tag;
    logic                          full;
    logic [CNT_W-1:0]              count;

    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB*ROB_WIDTH-1:0]  cdb_tag;
    logic [NUM_CDB*32-1:0]         cdb_data;

    logic                          issue_valid;
    logic                          issue_ready;
    logic [OP_WIDTH-1:0]           issue_op;
    logic [31:0]                   issue_a;
    logic [31:0]                   issue_b;
    logic [31:0]                   issue_imm;
    logic [31:0]                   issue_pc;
    logic [ROB_WIDTH-1:0]          issue_tag;

    modport master (
        output disp_valid, disp_op, disp_vj, disp_vk, disp_qj_valid, disp_qk_valid,
               disp_qj, disp_qk, disp_imm, disp_pc, disp_tag,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  full, count, issue_valid, issue_op, issue_a, issue_b,
               issue_imm, issue_pc, issue_tag
    );

    modport slave (
        input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj_valid, disp_qk_valid,
               disp_qj, disp_qk, disp_imm, disp_pc, disp_tag,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output full, count, issue_valid, issue_op, issue_a, issue_b,
               issue_imm, issue_pc, issue_tag
    );

endinterface

// File: rtl/rs_age_select.sv
// ---------------------------------------------------------------------------
// rs_age_select: age matrix and oldest-ready picker for N station slots.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   en             : global enable (rdy_in); low holds the matrix
//   alloc          : one-hot slot allocated this edge (becomes youngest)
//   free           : slots released this edge (one-hot, or all on flush)
//   ready          : slots eligible for issue
//   grant          : one-hot oldest ready slot; grant_valid = any ready
// older_q[i][j] = 1 means slot i was allocated before slot j.
// ---------------------------------------------------------------------------
module rs_age_select #(
    parameter int N = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         en,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] free,
    input  logic [N-1:0] ready,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    logic [N-1:0] older_q [N];

    // NOTE: state is updated with non-blocking assignments so every bit of
    // the matrix sees the pre-edge values regardless of loop order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N; i++) older_q[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i != j) begin
                        if (alloc[i])      older_q[i][j] <= 1'b0; // new slot is youngest
                        else if (alloc[j]) older_q[i][j] <= 1'b1; // everyone predates it
                        else if (free[i])  older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // A ready slot wins when no other ready slot is older than it. Busy slots
    // form a total order, so at most one grant bit is set.
    // NOTE: every variable assigned here gets a default before any condition,
    // so no path leaves it holding a value (no latch).
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j] && older_q[j][i]) blocked = 1'b1;
            end
            grant[i] = ready[i] && !blocked;
        end
    end

    assign grant_valid = |ready;

endmodule

// File: rtl/rs_alu_station.sv
// ---------------------------------------------------------------------------
// rs_alu_station: reservation station between rename/dispatch and one ALU.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   rdy_in         : global enable; low freezes every register
//   clear          : synchronous flush on mispredict (wins over everything)
//   bus (slave)    : dispatch in, CDB in, issue out (see rs_alu_station_if)
// Ops are written into the lowest free slot, capture operands from the CDB
// (also in the dispatch cycle), and the oldest ready slot is moved into the
// issue register whenever that register is empty or being consumed.
// ROB_WIDTH / OP_WIDTH must equal the core widths in rs_pkg.
// ---------------------------------------------------------------------------
module rs_alu_station
    import rs_pkg::*;
#(
    parameter int ROB_WIDTH = RS_TAG_W,
    parameter int RS_SIZE   = 8,
    parameter int NUM_CDB   = 2,
    parameter int OP_WIDTH  = RS_OP_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    rs_alu_station_if.slave  bus
);

    localparam int CNT_W = $clog2(RS_SIZE) + 1;

    rs_entry_t            ent_q [RS_SIZE];
    rs_entry_t            ent_d [RS_SIZE];
    rs_entry_t            disp_ent;

    logic [RS_SIZE-1:0]   busy_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [RS_SIZE-1:0]   alloc_oh;
    logic [RS_SIZE-1:0]   free_oh;
    logic [RS_SIZE-1:0]   age_alloc;
    logic [RS_SIZE-1:0]   age_free;
    logic [RS_SIZE-1:0]   grant;
    logic                 grant_valid;

    logic                 accept;
    logic                 load_en;
    logic                 do_issue;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 full_q;

    logic [RS_OP_W-1:0]   sel_op;
    logic [31:0]          sel_vj, sel_vk, sel_imm, sel_pc;
    logic [RS_TAG_W-1:0]  sel_tag;

    logic                 iss_valid_q;
    logic [OP_WIDTH-1:0]  iss_op_q;
    logic [31:0]          iss_a_q, iss_b_q, iss_imm_q, iss_pc_q;
    logic [ROB_WIDTH-1:0] iss_tag_q;

    // Returns {hit, data} for a producer tag; scanning from the top channel
    // down lets the lowest matching channel overwrite the others.
    function automatic logic [32:0] cdb_lookup(
        input logic [ROB_WIDTH-1:0]         tag,
        input logic [NUM_CDB-1:0]           valid,
        input logic [NUM_CDB*ROB_WIDTH-1:0] tags,
        input logic [NUM_CDB*32-1:0]        data
    );
        logic [32:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (valid[c] && tags[c*ROB_WIDTH +: ROB_WIDTH] == tag)
                res = {1'b1, data[c*32 +: 32]};
        end
        return res;
    endfunction

    // ---------------- slot status and allocation ----------------
    always_comb begin
        logic found;
        found    = 1'b0;
        alloc_oh = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && !ent_q[i].qj_pend && !ent_q[i].qk_pend;
            if (!ent_q[i].busy && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // full is registered and equals "no free slot", so alloc_oh is non-zero
    // whenever a dispatch is accepted.
    assign accept   = bus.disp_valid && !full_q;
    assign load_en  = !iss_valid_q || bus.issue_ready;
    assign do_issue = load_en && grant_valid;
    assign free_oh  = do_issue ? grant : '0;
    assign count_d  = count_q + CNT_W'(accept) - CNT_W'(do_issue);

    assign age_alloc = (accept && !clear) ? alloc_oh : '0;
    assign age_free  = clear ? '1 : free_oh;

    rs_age_select #(.N(RS_SIZE)) u_age (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en          (rdy_in),
        .alloc       (age_alloc),
        .free        (age_free),
        .ready       (ready_vec),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // ---------------- incoming entry with dispatch-time bypass ----------------
    always_comb begin
        logic [32:0] hit_j, hit_k;
        hit_j = cdb_lookup(bus.disp_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        hit_k = cdb_lookup(bus.disp_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

        disp_ent         = '0;
        disp_ent.busy    = 1'b1;
        disp_ent.op      = RS_OP_W'(bus.disp_op);
        disp_ent.vj      = bus.disp_vj;
        disp_ent.vk      = bus.disp_vk;
        disp_ent.qj_pend = bus.disp_qj_valid;
        disp_ent.qk_pend = bus.disp_qk_valid;
        disp_ent.qj      = RS_TAG_W'(bus.disp_qj);
        disp_ent.qk      = RS_TAG_W'(bus.disp_qk);
        disp_ent.imm     = bus.disp_imm;
        disp_ent.pc      = bus.disp_pc;
        disp_ent.tag     = RS_TAG_W'(bus.disp_tag);

        if (bus.disp_qj_valid && hit_j[32]) begin
            disp_ent.vj      = hit_j[31:0];
            disp_ent.qj_pend = 1'b0;
        end
        if (bus.disp_qk_valid && hit_k[32]) begin
            disp_ent.vk      = hit_k[31:0];
            disp_ent.qk_pend = 1'b0;
        end
    end

    // ---------------- per-slot next state: free, wakeup, allocate ----------------
    always_comb begin
        logic [32:0] hit_j, hit_k;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            hit_j    = cdb_lookup(ROB_WIDTH'(ent_q[i].qj), bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            hit_k    = cdb_lookup(ROB_WIDTH'(ent_q[i].qk), bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (free_oh[i]) begin
                ent_d[i].busy = 1'b0;
            end else if (ent_q[i].busy) begin
                if (ent_q[i].qj_pend && hit_j[32]) begin
                    ent_d[i].vj      = hit_j[31:0];
                    ent_d[i].qj_pend = 1'b0;
                end
                if (ent_q[i].qk_pend && hit_k[32]) begin
                    ent_d[i].vk      = hit_k[31:0];
                    ent_d[i].qk_pend = 1'b0;
                end
            end
            // alloc_oh only ever points at a slot that is not busy now, so a
            // slot freed by this edge's issue is never the target.
            if (accept && alloc_oh[i]) ent_d[i] = disp_ent;
        end
    end

    // ---------------- issue selection mux ----------------
    always_comb begin
        sel_op  = '0;
        sel_vj  = '0;
        sel_vk  = '0;
        sel_imm = '0;
        sel_pc  = '0;
        sel_tag = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) begin
                sel_op  = ent_q[i].op;
                sel_vj  = ent_q[i].vj;
                sel_vk  = ent_q[i].vk;
                sel_imm = ent_q[i].imm;
                sel_pc  = ent_q[i].pc;
                sel_tag = ent_q[i].tag;
            end
        end
    end

    // ---------------- state registers ----------------
    // NOTE: the slot array is fully reset rather than only its busy bits, so
    // the issue path never carries X after reset; the array is small.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_imm_q   <= '0;
            iss_pc_q    <= '0;
            iss_tag_q   <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
                count_q     <= '0;
                full_q      <= 1'b0;
                iss_valid_q <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
                count_q <= count_d;
                full_q  <= (count_d == CNT_W'(RS_SIZE));
                if (load_en) begin
                    iss_valid_q <= grant_valid;
                    if (grant_valid) begin
                        iss_op_q  <= OP_WIDTH'(sel_op);
                        iss_a_q   <= sel_vj;
                        iss_b_q   <= sel_vk;
                        iss_imm_q <= sel_imm;
                        iss_pc_q  <= sel_pc;
                        iss_tag_q <= ROB_WIDTH'(sel_tag);
                    end
                end
            end
        end
    end

    assign bus.full        = full_q;
    assign bus.count       = count_q;
    assign bus.issue_valid = iss_valid_q;
    assign bus.issue_op    = iss_op_q;
    assign bus.issue_a     = iss_a_q;
    assign bus.issue_b     = iss_b_q;
    assign bus.issue_imm   = iss_imm_q;
    assign bus.issue_pc    = iss_pc_q;
    assign bus.issue_tag   = iss_tag_q;

endmodule
